// File: rtl/matmul_pool_engine.sv
// 4x4 unsigned 8-bit matrix multiply followed by 2x2 average pooling with saturation.
// Operands are fetched row-by-row from a word memory; the pooled bytes are written back as one word.
//
// state        | meaning
// IDLE         | ready high, waiting for kick_start
// READ_A       | issue 4 A-row reads, capture rows one cycle behind (5 cycles)
// READ_B       | same as READ_A for the B operand
// MAC_COMPUTE  | one C element per cycle, row-major (16 cycles)
// AVERAGE_POOL | reduce C quadrants to 4 saturated bytes
// STORE_RESULT | pack pooled bytes, load write port registers
// WRITE_BACK   | write strobe high for one cycle, then IDLE
module matmul_pool_engine #(
  parameter logic [9:0] A_BASE = 10'h000,
  parameter logic [9:0] B_BASE = 10'h100,
  parameter logic [9:0] C_ADDR = 10'h200
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        kick_start,
  output logic        ready,
  output logic        mem_read_en_A,
  output logic [9:0]  mem_addr_A,
  input  logic [31:0] mem_data_A,
  output logic        mem_read_en_B,
  output logic [9:0]  mem_addr_B,
  input  logic [31:0] mem_data_B,
  output logic        mem_write_en_C,
  output logic [9:0]  mem_addr_C,
  output logic [31:0] mem_data_C
);

  typedef enum logic [2:0] {
    IDLE, READ_A, READ_B, MAC_COMPUTE, AVERAGE_POOL, STORE_RESULT, WRITE_BACK
  } state_t;

  state_t      state;
  logic [3:0]  tmr;
  logic [7:0]  a_mat [0:3][0:3];
  logic [7:0]  b_mat [0:3][0:3];
  logic [17:0] c_mat [0:3][0:3];
  logic [7:0]  pool_q [0:3];

  logic [3:0]  elem;
  logic [1:0]  mi, mj;
  logic [1:0]  cap_row;
  logic [9:0]  rd_ofs;
  logic [17:0] mac_sum;
  logic [7:0]  pool_val [0:3];

  // tmr counts down; the phase index is recovered from how far it has run
  assign elem    = 4'd15 - tmr;
  assign mi      = elem[3:2];
  assign mj      = elem[1:0];
  assign cap_row = 2'd3 - tmr[1:0];
  assign rd_ofs  = 10'(4'd5 - tmr);

  always_comb begin
    mac_sum = '0;
    for (int k = 0; k < 4; k++) begin
      mac_sum = mac_sum + 18'(a_mat[mi][k]) * 18'(b_mat[k][mj]);
    end
  end

  for (genvar gp = 0; gp < 2; gp++) begin : g_pool_row
    for (genvar gq = 0; gq < 2; gq++) begin : g_pool_col
      logic [19:0] quad_sum;
      logic [17:0] avg;
      assign quad_sum = 20'(c_mat[2*gp][2*gq])   + 20'(c_mat[2*gp][2*gq+1]) +
                        20'(c_mat[2*gp+1][2*gq]) + 20'(c_mat[2*gp+1][2*gq+1]);
      assign avg = 18'(quad_sum >> 2);
      assign pool_val[2*gp+gq] = (avg > 18'd255) ? 8'hFF : avg[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state          <= IDLE;
      ready          <= 1'b1;
      tmr            <= '0;
      mem_read_en_A  <= 1'b0;
      mem_addr_A     <= '0;
      mem_read_en_B  <= 1'b0;
      mem_addr_B     <= '0;
      mem_write_en_C <= 1'b0;
      mem_addr_C     <= '0;
      mem_data_C     <= '0;
      for (int r = 0; r < 4; r++) begin
        pool_q[r] <= '0;
        for (int c = 0; c < 4; c++) begin
          a_mat[r][c] <= '0;
          b_mat[r][c] <= '0;
          c_mat[r][c] <= '0;
        end
      end
    end else begin
      // strobes and addresses fall back to zero unless a state drives them
      mem_read_en_A  <= 1'b0;
      mem_addr_A     <= '0;
      mem_read_en_B  <= 1'b0;
      mem_addr_B     <= '0;
      mem_write_en_C <= 1'b0;
      mem_addr_C     <= '0;
      mem_data_C     <= '0;
      case (state)
        IDLE: begin
          if (kick_start) begin
            state         <= READ_A;
            ready         <= 1'b0;
            tmr           <= 4'd4;
            mem_read_en_A <= 1'b1;
            mem_addr_A    <= A_BASE;
          end
        end
        READ_A: begin
          if (tmr != 4'd4) begin
            for (int c = 0; c < 4; c++) a_mat[cap_row][c] <= mem_data_A[8*c +: 8];
          end
          if (tmr >= 4'd2) begin
            mem_read_en_A <= 1'b1;
            mem_addr_A    <= A_BASE + rd_ofs;
          end
          if (tmr == 4'd0) begin
            state         <= READ_B;
            tmr           <= 4'd4;
            mem_read_en_B <= 1'b1;
            mem_addr_B    <= B_BASE;
          end else begin
            tmr <= tmr - 4'd1;
          end
        end
        READ_B: begin
          if (tmr != 4'd4) begin
            for (int c = 0; c < 4; c++) b_mat[cap_row][c] <= mem_data_B[8*c +: 8];
          end
          if (tmr >= 4'd2) begin
            mem_read_en_B <= 1'b1;
            mem_addr_B    <= B_BASE + rd_ofs;
          end
          if (tmr == 4'd0) begin
            state <= MAC_COMPUTE;
            tmr   <= 4'd15;
          end else begin
            tmr <= tmr - 4'd1;
          end
        end
        MAC_COMPUTE: begin
          c_mat[mi][mj] <= mac_sum;
          if (tmr == 4'd0) state <= AVERAGE_POOL;
          else             tmr   <= tmr - 4'd1;
        end
        AVERAGE_POOL: begin
          for (int p = 0; p < 4; p++) pool_q[p] <= pool_val[p];
          state <= STORE_RESULT;
        end
        STORE_RESULT: begin
          mem_write_en_C <= 1'b1;
          mem_addr_C     <= C_ADDR;
          mem_data_C     <= {pool_q[3], pool_q[2], pool_q[1], pool_q[0]};
          state          <= WRITE_BACK;
        end
        WRITE_BACK: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_pool_engine.sv
// Randomized scoreboard bench for matmul_pool_engine with a word-memory model and
// an arithmetic reference model of the multiply/pool/saturate result.
module tb_matmul_pool_engine;

  localparam int A_BASE = 'h000;
  localparam int B_BASE = 'h100;
  localparam int C_ADDR = 'h200;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        kick_start = 1'b0;
  logic        ready;
  logic        mem_read_en_A, mem_read_en_B, mem_write_en_C;
  logic [9:0]  mem_addr_A, mem_addr_B, mem_addr_C;
  logic [31:0] mem_data_A, mem_data_B, mem_data_C;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int cyc      = 0;

  logic [31:0] exp_q [$];
  logic [9:0]  a_addr_q [$];
  logic [9:0]  b_addr_q [$];
  int          a_stamp [$];
  int          b_stamp [$];

  always #5 clk = ~clk;

  matmul_pool_engine dut (
    .clk(clk), .rstn(rstn), .kick_start(kick_start), .ready(ready),
    .mem_read_en_A(mem_read_en_A), .mem_addr_A(mem_addr_A), .mem_data_A(mem_data_A),
    .mem_read_en_B(mem_read_en_B), .mem_addr_B(mem_addr_B), .mem_data_B(mem_data_B),
    .mem_write_en_C(mem_write_en_C), .mem_addr_C(mem_addr_C), .mem_data_C(mem_data_C)
  );

  // registered-read, write-on-edge memory
  always @(posedge clk) begin
    if (mem_read_en_A) mem_data_A <= mem[mem_addr_A];
    if (mem_read_en_B) mem_data_B <= mem[mem_addr_B];
    if (mem_write_en_C) mem[mem_addr_C] = mem_data_C;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mem_read_en_A === 1'b1) begin a_addr_q.push_back(mem_addr_A); a_stamp.push_back(cyc); end
    if (mem_read_en_B === 1'b1) begin b_addr_q.push_back(mem_addr_B); b_stamp.push_back(cyc); end
    if (mem_write_en_C === 1'b1) begin
      n_writes++;
      check("write_addr", 32'(mem_addr_C), 32'(C_ADDR));
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got %h expected no write", mem_data_C);
      end else begin
        check("write_data", mem_data_C, exp_q.pop_front());
      end
    end
  end

  function automatic logic [7:0] elem_val(int kind, int r, int c, int mx);
    case (kind)
      0:       return 8'(r * 4 + c + 1);
      1:       return (r == c) ? 8'd1 : 8'd0;
      2:       return 8'd2;
      3:       return 8'd255;
      default: return 8'($urandom_range(0, mx));
    endcase
  endfunction

  task automatic load(input int kind_a, input int kind_b, input int mx);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mem[A_BASE + r][8*c +: 8] = elem_val(kind_a, r, c, mx);
        mem[B_BASE + r][8*c +: 8] = elem_val(kind_b, r, c, mx);
      end
  endtask

  // C = A*B with integers, average each quadrant, clamp to a byte, byte 2p+q holds P[p][q]
  function automatic logic [31:0] ref_result();
    int a [4][4];
    int b [4][4];
    int cm [4][4];
    int s, v;
    logic [31:0] res;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a[r][c] = int'(mem[A_BASE + r][8*c +: 8]);
        b[r][c] = int'(mem[B_BASE + r][8*c +: 8]);
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        cm[i][j] = 0;
        for (int k = 0; k < 4; k++) cm[i][j] += a[i][k] * b[k][j];
      end
    res = '0;
    for (int p = 0; p < 2; p++)
      for (int q = 0; q < 2; q++) begin
        s = cm[2*p][2*q] + cm[2*p][2*q+1] + cm[2*p+1][2*q] + cm[2*p+1][2*q+1];
        v = s / 4;
        if (v > 255) v = 255;
        res[8*(2*p+q) +: 8] = v[7:0];
      end
    return res;
  endfunction

  task automatic wait_ready(input int kick_again_at, output int low);
    low = 0;
    while (ready !== 1'b1 && low < 100) begin
      low++;
      if (kick_again_at >= 0) kick_start = (low == kick_again_at);
      @(negedge clk);
    end
    if (kick_again_at >= 0) kick_start = 1'b0;
  endtask

  // one run from a negedge in IDLE; optional stray kick at a cycle inside the run
  task automatic run(input int kick_again_at);
    int low, w0;
    a_addr_q.delete(); b_addr_q.delete(); a_stamp.delete(); b_stamp.delete();
    w0 = n_writes;
    exp_q.push_back(ref_result());
    kick_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kick_start = 1'b0;
    wait_ready(kick_again_at, low);
    check("ready_low_cycles", low, 29);
    check("one_write", n_writes - w0, 1);
    check("a_read_count", a_addr_q.size(), 4);
    check("b_read_count", b_addr_q.size(), 4);
    if (a_addr_q.size() == 4 && b_addr_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("a_read_addr", 32'(a_addr_q[k]), 32'(A_BASE + k));
        check("b_read_addr", 32'(b_addr_q[k]), 32'(B_BASE + k));
        check("a_read_cycle", a_stamp[k] - a_stamp[0], k);
        check("b_read_cycle", b_stamp[k] - a_stamp[0], k + 5);
      end
    end
  endtask

  initial begin
    int low, w0;
    int mxs [3] = '{15, 63, 255};
    load(0, 0, 0);
    mem[C_ADDR] = 32'hDEAD_BEEF;
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(ready), 1);
    check("reset_strobes", {29'd0, mem_read_en_A, mem_read_en_B, mem_write_en_C}, 0);
    check("reset_data_c", mem_data_C, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_ready", 32'(ready), 1);
    check("idle_addrs", {2'd0, mem_addr_A, mem_addr_B, mem_addr_C}, 0);
    check("idle_no_write", n_writes, 0);
    check("idle_mem_c", mem[C_ADDR], 32'hDEAD_BEEF);

    run(-1);
    check("default_result", mem[C_ADDR], 32'hFFFF_BF9B);

    load(1, 2, 0);
    run(-1);
    check("identity_result", mem[C_ADDR], 32'h0202_0202);

    load(3, 3, 0);
    run(-1);
    check("saturate_result", mem[C_ADDR], 32'hFFFF_FFFF);

    load(0, 0, 0);
    run(10);

    for (int n = 0; n < 6; n++) begin
      load(4, 4, mxs[n % 3]);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(-1);
    end

    // kick held across the return to IDLE restarts after one ready cycle
    load(4, 4, 15);
    w0 = n_writes;
    exp_q.push_back(ref_result());
    exp_q.push_back(ref_result());
    kick_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_ready(-1, low);
    check("held_first_low", low, 29);
    @(posedge clk);
    @(negedge clk);
    check("held_restart", 32'(ready), 0);
    kick_start = 1'b0;
    wait_ready(-1, low);
    check("held_second_low", low, 29);
    check("held_two_writes", n_writes - w0, 2);

    // reset in the middle of MAC_COMPUTE aborts without writing
    load(0, 0, 0);
    mem[C_ADDR] = 32'h1234_5678;
    w0 = n_writes;
    kick_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kick_start = 1'b0;
    repeat (14) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    check("abort_ready", 32'(ready), 1);
    check("abort_strobes", {29'd0, mem_read_en_A, mem_read_en_B, mem_write_en_C}, 0);
    repeat (40) @(negedge clk);
    check("abort_no_write", n_writes - w0, 0);
    check("abort_mem_c", mem[C_ADDR], 32'h1234_5678);
    check("abort_still_idle", 32'(ready), 1);

    load(4, 4, 15);
    run(-1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/matmul_pool_engine.md
# matmul_pool_engine

Fixed-size 4×4 unsigned 8-bit matrix multiplier with 2×2 average pooling. On a start pulse it reads matrix A and matrix B from a 1024×32 word memory, computes C = A×B, reduces C to a 2×2 matrix by averaging each 2×2 quadrant, saturates each value to 8 bits, and writes the four pooled bytes back to memory as one packed word. It sits between a control master (start/ready handshake) and a three-port word memory: read port A, read port B, write port C.

## Interface
- `A_BASE`, 10'h000: word address of A row 0; rows are at A_BASE+0..3.
- `B_BASE`, 10'h100: word address of B row 0; rows are at B_BASE+0..3.
- `C_ADDR`, 10'h200: word address of the pooled result.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rstn`  in  1  reset, synchronous and active-high (1 = reset).
- `kick_start`  in  1  start pulse, sampled only in IDLE.
- `ready`  out  1  high exactly while in IDLE.
- `mem_read_en_A`  out  1  read strobe for the A port.
- `mem_addr_A`  out  10  A read address.
- `mem_data_A`  in  32  A read data, valid one cycle after the strobe.
- `mem_read_en_B`, `mem_addr_B`, `mem_data_B`: same as the A port, for B.
- `mem_write_en_C`  out  1  result write strobe.
- `mem_addr_C`  out  10  result address.
- `mem_data_C`  out  32  packed result.

## Operation
- Row packing in memory: word r holds row r; bits [8c+7:8c] hold column c. Byte 0 is column 0.
- All elements are unsigned 8-bit.
- State sequence: IDLE → READ_A → READ_B → MAC_COMPUTE → AVERAGE_POOL → STORE_RESULT → WRITE_BACK → IDLE.
- IDLE: `ready`=1. `kick_start`=1 moves to READ_A. All memory strobes are low in IDLE.
- READ_A (5 cycles): in cycle k (k=0..3), assert `mem_read_en_A` with address A_BASE+k. Capture `mem_data_A` into A row k in cycle k+1.
- READ_B: identical to READ_A, using port B and B_BASE.
- MAC_COMPUTE (16 cycles): one element per cycle, row-major order.
  - C[i][j] = Σk A[i][k]·B[k][j], computed at 18 bits unsigned.
  - Stored without truncation.
- AVERAGE_POOL (1 cycle): P[p][q] = (sum of C[2p..2p+1][2q..2q+1]) >> 2.
  - Sum is 20 bits; the shift floors the result.
  - If the result exceeds 255, P[p][q] = 255.
- STORE_RESULT (1 cycle): pack the result word as {P[1][1], P[1][0], P[0][1], P[0][0]}, bits 31 down to 0.
- WRITE_BACK (1 cycle): `mem_write_en_C`=1, `mem_addr_C`=C_ADDR, `mem_data_C`=packed word. Then return to IDLE.
- Exactly one write is issued per run. A and B are never written.
- `kick_start` outside IDLE is ignored. It is never queued.
- Memory strobes and addresses are registered outputs. They are 0 whenever inactive.

## Timing
- Reset (while `rstn`=1 at a clock edge):
  - state = IDLE, so `ready`=1 from the first cycle after reset.
  - All strobes, addresses and `mem_data_C` = 0.
  - Matrix and accumulator registers cleared.
- Reset asserted mid-run aborts the run at the next edge. No write is issued. Memory contents are unaffected.
- Latency: the edge that samples `kick_start` enters READ_A. The run is READ_A 5 + READ_B 5 + MAC 16 + 1 + 1 + 1 = 29 cycles; `ready` returns high on the 30th edge.
- `ready` falls on the edge after `kick_start` is sampled and stays low until return to IDLE.
- `kick_start` held high across the return to IDLE starts a new run immediately.
- Memory contract:
  - 1024×32 array.
  - Registered read: data appears the cycle after the strobe.
  - Write on the rising edge when the write strobe is high.
  - Contents are not cleared by reset, so they may be preloaded before reset or between runs.
  - Simulation model initial contents: A and B rows = [1,2,3,4], [5,6,7,8], [9,10,11,12], [13,14,15,16].

## Test plan
- Reset, then wait → `ready`=1, all strobes 0, no memory write.
- Default A = B = [[1..4],…,[13..16]], one-cycle `kick_start`:
  - C rows = [90,100,110,120], [202,228,254,280], [314,356,398,440], [426,484,542,600].
  - mem[0x200] = 32'hFFFF_BF9B, bytes [155,191,255,255].
- Preload A = identity, B = all 2s, start → mem[0x200] = 32'h0202_0202.
- All elements 255, start → every C = 260100; pooled values saturate; mem[0x200] = 32'hFFFF_FFFF.
- Latency check:
  - `ready` low for exactly 29 cycles.
  - A reads at 0x000..0x003 and B reads at 0x100..0x103, one per cycle.
  - Exactly one write, at 0x200.
- `kick_start` pulsed mid-run → ignored, single write. `rstn` pulsed mid-MAC → IDLE next cycle, no write, mem[0x200] unchanged.
